config_mac_pipelined: RTL

//   Parametrised, pipelined successor of the configurable 4-bit multiplier.

---
 rtl/config_mac_pipelined.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/config_mac_pipelined.sv
// Signed multiply-accumulate with 1/2/4 runtime-selectable lanes and a two-stage valid/ready pipeline.
// Stage 1 registers the lane products; stage 2 folds them into the per-lane wrapping accumulators.
module config_mac_pipelined #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [WIDTH-1:0]       multiplier_i,
    input  logic [WIDTH-1:0]       multiplicand_i,
    input  logic [1:0]             mode_i,
    input  logic                   accumulate_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [2*WIDTH-1:0]     product_o,
    output logic [ACC_WIDTH-1:0]   acc_o,
    output logic [1:0]             mode_o
);

    localparam int PW   = 2 * WIDTH;
    localparam int HALF = WIDTH / 2;
    localparam int QTR  = WIDTH / 4;
    localparam int AH   = ACC_WIDTH / 2;
    localparam int AQ   = ACC_WIDTH / 4;

    logic                 s1ValidReg;
    logic [PW-1:0]        s1ProductReg;
    logic [1:0]           s1ModeReg;
    logic                 s1AccumulateReg;
    logic                 s2ValidReg;
    logic [PW-1:0]        productReg;
    logic [ACC_WIDTH-1:0] accReg;
    logic [1:0]           modeReg;

    logic                 s1Advance;
    logic                 s2Advance;
    logic [1:0]           modeIn;
    logic [PW-1:0]        prodFull;
    logic [PW-1:0]        prodHalf;
    logic [PW-1:0]        prodQtr;
    logic [PW-1:0]        productNext;
    logic                 restart;
    logic [ACC_WIDTH-1:0] accFullNext;
    logic [ACC_WIDTH-1:0] accHalfNext;
    logic [ACC_WIDTH-1:0] accQtrNext;
    logic [ACC_WIDTH-1:0] accNext;

    assign s2Advance  = !s2ValidReg || out_ready_i;
    assign s1Advance  = !s1ValidReg || s2Advance;
    assign in_ready_o = s1Advance;

    // Mode 11 is folded into 00 at the input so everything downstream sees three modes.
    assign modeIn = (mode_i == 2'b11) ? 2'b00 : mode_i;

    assign prodFull = PW'(signed'(multiplier_i)) * PW'(signed'(multiplicand_i));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gHalfMul
            logic signed [HALF-1:0] a;
            logic signed [HALF-1:0] b;
            assign a = multiplier_i[gi*HALF +: HALF];
            assign b = multiplicand_i[gi*HALF +: HALF];
            assign prodHalf[gi*WIDTH +: WIDTH] = WIDTH'(a) * WIDTH'(b);
        end
        for (genvar gi = 0; gi < 4; gi++) begin : gQtrMul
            logic signed [QTR-1:0] a;
            logic signed [QTR-1:0] b;
            assign a = multiplier_i[gi*QTR +: QTR];
            assign b = multiplicand_i[gi*QTR +: QTR];
            assign prodQtr[gi*HALF +: HALF] = HALF'(a) * HALF'(b);
        end
    endgenerate

    always_comb begin
        productNext = prodFull;
        case (modeIn)
            2'b01:   productNext = prodHalf;
            2'b10:   productNext = prodQtr;
            default: productNext = prodFull;
        endcase
    end

    // modeReg doubles as the accumulators' stored mode: it is the mode of the last result in S2.
    assign restart = !(s1AccumulateReg && (s1ModeReg == modeReg));

    assign accFullNext = (restart ? '0 : accReg) + ACC_WIDTH'(signed'(s1ProductReg));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gHalfAcc
            assign accHalfNext[gi*AH +: AH] = (restart ? '0 : accReg[gi*AH +: AH])
                                            + AH'(signed'(s1ProductReg[gi*WIDTH +: WIDTH]));
        end
        for (genvar gi = 0; gi < 4; gi++) begin : gQtrAcc
            assign accQtrNext[gi*AQ +: AQ] = (restart ? '0 : accReg[gi*AQ +: AQ])
                                           + AQ'(signed'(s1ProductReg[gi*HALF +: HALF]));
        end
    endgenerate

    always_comb begin
        accNext = accFullNext;
        case (s1ModeReg)
            2'b01:   accNext = accHalfNext;
            2'b10:   accNext = accQtrNext;
            default: accNext = accFullNext;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1ValidReg      <= 1'b0;
            s1ProductReg    <= '0;
            s1ModeReg       <= 2'b00;
            s1AccumulateReg <= 1'b0;
        end else if (s1Advance) begin
            s1ValidReg <= in_valid_i;
            if (in_valid_i) begin
                s1ProductReg    <= productNext;
                s1ModeReg       <= modeIn;
                s1AccumulateReg <= accumulate_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2ValidReg <= 1'b0;
            productReg <= '0;
            accReg     <= '0;
            modeReg    <= 2'b00;
        end else if (s2Advance) begin
            s2ValidReg <= s1ValidReg;
            if (s1ValidReg) begin
                productReg <= s1ProductReg;
                accReg     <= accNext;
                modeReg    <= s1ModeReg;
            end
        end
    end

    assign out_valid_o = s2ValidReg;
    assign product_o   = productReg;
    assign acc_o       = accReg;
    assign mode_o      = modeReg;

endmodule
